tx_ethernet: RTL

Ethernet II transmit framer: the transmit counterpart of `rx_ethernet`. It takes a destination MAC, EtherType and a byte-streamed payload and drives a GMII transmit byte stream. The stream carries preamble, SFD, MAC header, payload, zero padding to the 64-byte minimum, CRC-32 FCS and the inter-frame gap. It sits below future `tx_ipv4` / `tx_udp` blocks, and its TX_EN/TXD/TX_ER outputs feed the GMII pins at top level.

---
 rtl/tx_ethernet_if.sv | 26 ++
 rtl/tx_ethernet.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_ethernet_if.sv
// tx_ethernet_if: frame request and payload handshake between a client
// and the tx_ethernet framer.
interface tx_ethernet_if;
    logic [47:0] tx_dst_mac;
    logic [15:0] tx_ethertype;
    logic        tx_start;
    logic        tx_busy;
    logic        tx_data_rdy;
    logic        tx_data_v;
    logic [7:0]  tx_data;
    logic        tx_data_last;
    logic        tx_done;
    logic        tx_err;

    modport master (
        output tx_dst_mac, tx_ethertype, tx_start,
        output tx_data_v, tx_data, tx_data_last,
        input  tx_busy, tx_data_rdy, tx_done, tx_err
    );

    modport slave (
        input  tx_dst_mac, tx_ethertype, tx_start,
        input  tx_data_v, tx_data, tx_data_last,
        output tx_busy, tx_data_rdy, tx_done, tx_err
    );
endinterface

// File: rtl/tx_ethernet.sv
// tx_ethernet: Ethernet II transmit framer producing a GMII byte stream
// (preamble, header, payload, zero pad, CRC-32 FCS, inter-frame gap).
module tx_ethernet #(
    parameter int         OCT         = 8,
    parameter logic [7:0] PRE         = 8'b10101010,
    parameter logic [7:0] SFD         = 8'b10101011,
    parameter int         MIN_PAYLOAD = 46,
    parameter int         MAX_PAYLOAD = 1500,
    parameter int         IFG         = 12
) (
    input  logic           RX_CLK,
    input  logic           rst,
    input  logic [47:0]    mac_addr,
    tx_ethernet_if.slave   bus,
    output logic           TX_EN,
    output logic [OCT-1:0] TXD,
    output logic           TX_ER
);

    localparam logic [10:0] MIN_P    = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_P    = 11'(MAX_PAYLOAD);
    localparam logic [3:0]  GAP_LAST = 4'(IFG - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_PRE, ST_SFD, ST_DST, ST_SRC, ST_TYPE,
        ST_PAYLOAD, ST_PAD, ST_FCS, ST_ERR, ST_GAP
    } state_t;

    // state/cnt always describe the byte currently on TXD
    state_t         state, state_n;
    logic [3:0]     cnt, cnt_n;
    logic [10:0]    pcnt, pcnt_n;
    logic [111:0]   hdr, hdr_n;
    logic [31:0]    crc, crc_n;
    logic [31:0]    fcs;
    logic           last_q, last_n;
    logic           ovr_q, ovr_n;
    logic [OCT-1:0] txd_n;
    logic           en_n, er_n, done_n, err_n;
    logic           done_q, err_q;
    logic           rdy;

    function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                            input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign fcs = ~crc;

    // next byte, next state and handshake for the byte after this one
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pcnt_n  = pcnt;
        hdr_n   = hdr;
        crc_n   = crc;
        last_n  = last_q;
        ovr_n   = ovr_q;
        txd_n   = '0;
        en_n    = 1'b0;
        er_n    = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        rdy = ((state == ST_TYPE) && (cnt == 4'd1)) ||
              ((state == ST_PAYLOAD) && !last_q);
        if (rdy) begin
            en_n = 1'b1;
            if (bus.tx_data_v) begin
                state_n = ST_PAYLOAD;
                txd_n   = bus.tx_data;
                pcnt_n  = pcnt + 11'd1;
                last_n  = bus.tx_data_last || (pcnt_n == MAX_P);
                ovr_n   = !bus.tx_data_last && (pcnt_n == MAX_P);
            end else begin
                // underrun: poisoned zero byte, then straight to the gap
                state_n = ST_ERR;
                er_n    = 1'b1;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.tx_start) begin
                        state_n = ST_PRE;
                        cnt_n   = '0;
                        pcnt_n  = '0;
                        last_n  = 1'b0;
                        ovr_n   = 1'b0;
                        hdr_n   = {bus.tx_dst_mac, mac_addr, bus.tx_ethertype};
                        en_n    = 1'b1;
                        txd_n   = PRE;
                    end
                end
                ST_PRE: begin
                    en_n = 1'b1;
                    if (cnt == 4'd6) begin
                        state_n = ST_SFD;
                        txd_n   = SFD;
                        crc_n   = 32'hFFFFFFFF;
                    end else begin
                        cnt_n = cnt + 4'd1;
                        txd_n = PRE;
                    end
                end
                ST_SFD, ST_DST, ST_SRC, ST_TYPE: begin
                    en_n  = 1'b1;
                    txd_n = hdr[111:104];
                    hdr_n = {hdr[103:0], 8'h00};
                    cnt_n = cnt + 4'd1;
                    if (state == ST_SFD) begin
                        state_n = ST_DST;
                        cnt_n   = '0;
                    end else if (state == ST_DST && cnt == 4'd5) begin
                        state_n = ST_SRC;
                        cnt_n   = '0;
                    end else if (state == ST_SRC && cnt == 4'd5) begin
                        state_n = ST_TYPE;
                        cnt_n   = '0;
                    end
                end
                ST_PAYLOAD, ST_PAD: begin
                    en_n = 1'b1;
                    if (pcnt < MIN_P) begin
                        state_n = ST_PAD;
                        pcnt_n  = pcnt + 11'd1;
                    end else begin
                        state_n = ST_FCS;
                        cnt_n   = '0;
                        txd_n   = fcs[7:0];
                    end
                end
                ST_FCS: begin
                    if (cnt == 4'd3) begin
                        state_n = ST_GAP;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                        err_n   = ovr_q;
                    end else begin
                        en_n  = 1'b1;
                        cnt_n = cnt + 4'd1;
                        unique case (cnt[1:0])
                            2'd0:    txd_n = fcs[15:8];
                            2'd1:    txd_n = fcs[23:16];
                            default: txd_n = fcs[31:24];
                        endcase
                    end
                end
                ST_ERR: begin
                    state_n = ST_GAP;
                    cnt_n   = '0;
                    err_n   = 1'b1;
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
        // FCS covers every byte from DST through PAD
        if (en_n && !er_n && (state_n inside {ST_DST, ST_SRC, ST_TYPE,
                                              ST_PAYLOAD, ST_PAD}))
            crc_n = crc_upd(crc, txd_n);
    end

    // state and registered GMII outputs
    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            pcnt   <= '0;
            hdr    <= '0;
            crc    <= 32'hFFFFFFFF;
            last_q <= 1'b0;
            ovr_q  <= 1'b0;
            TX_EN  <= 1'b0;
            TXD    <= '0;
            TX_ER  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            pcnt   <= pcnt_n;
            hdr    <= hdr_n;
            crc    <= crc_n;
            last_q <= last_n;
            ovr_q  <= ovr_n;
            TX_EN  <= en_n;
            TXD    <= txd_n;
            TX_ER  <= er_n;
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    assign bus.tx_busy     = (state != ST_IDLE);
    assign bus.tx_data_rdy = rdy;
    assign bus.tx_done     = done_q;
    assign bus.tx_err      = err_q;

endmodule
